// File: rtl/ring_arbiter.sv
// ring_arbiter: round-robin arbiter with a one-hot ring pointer; grants are held until release.
// Define RING_ARB_TIMEOUT_EN to forcibly revoke a grant after HOLD_MAX cycles.
module ring_arbiter #(
    parameter int N        = 4,
    parameter int HOLD_MAX = 15,
    parameter int CW       = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [N-1:0]                        req,
    input  logic                                done,
    output logic [N-1:0]                        grant,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] owner,
    output logic                                busy,
    output logic [N-1:0]                        ptr,
    output logic                                timeout
);
    localparam int OW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state;
    logic [N-1:0]  below;
    logic [N-1:0]  pick;
    logic [N-1:0]  ptr_nxt;
    logic [OW-1:0] sel;
    logic          rel;
    logic          expire;

`ifdef RING_ARB_TIMEOUT_EN
    logic [CW-1:0] cnt;
    assign expire = cnt == CW'(HOLD_MAX - 1);
`else
    logic [CW-1:0] unused_hold;
    assign unused_hold = CW'(HOLD_MAX);
    assign expire      = 1'b0;
`endif

    // Requests at or above the pointer win; otherwise wrap around to the lowest request.
    assign below = ptr - N'(1);
    assign pick  = |(req & ~below) ? (req & ~below) : req;
    assign rel   = done || !req[owner];

    always_comb begin
        sel = '0;
        for (int i = N - 1; i >= 0; i--)
            if (pick[i]) sel = OW'(i);
    end

    // Priority moves to the slot just past the releasing owner.
    always_comb begin
        ptr_nxt = '0;
        for (int i = 0; i < N; i++)
            ptr_nxt[i] = grant[(i + N - 1) % N];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            grant   <= '0;
            owner   <= '0;
            busy    <= 1'b0;
            timeout <= 1'b0;
            ptr     <= N'(1);
`ifdef RING_ARB_TIMEOUT_EN
            cnt     <= '0;
`endif
        end else begin
            timeout <= 1'b0;
            if (state == IDLE) begin
                if (|req) begin
                    state <= GRANT;
                    grant <= N'(1) << sel;
                    owner <= sel;
                    busy  <= 1'b1;
`ifdef RING_ARB_TIMEOUT_EN
                    cnt   <= '0;
`endif
                end
            end else if (rel || expire) begin
                state   <= IDLE;
                grant   <= '0;
                owner   <= '0;
                busy    <= 1'b0;
                ptr     <= ptr_nxt;
                timeout <= !rel;
            end else begin
`ifdef RING_ARB_TIMEOUT_EN
                cnt <= cnt + CW'(1);
`endif
            end
        end
    end
endmodule

// File: tb/tb_ring_arbiter.sv
// tb_ring_arbiter: directed checks of reset, rotation, wrap, withdrawal and hold/timeout behaviour.
module tb_ring_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] owner;
    logic       busy;
    logic [3:0] ptr;
    logic       timeout;
    int         checks = 0;
    int         errors = 0;

    ring_arbiter #(.N(4), .HOLD_MAX(15), .CW(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done), .grant(grant),
        .owner(owner), .busy(busy), .ptr(ptr), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] rot [5];
        int bad;
        rot = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst_n = 1'b0; req = '0; done = 1'b0;
        #12;
        chk("rst_grant", grant, 4'b0000);
        chk("rst_ptr", ptr, 4'b0001);
        chk("rst_busy", busy, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_owner", owner, 0);
        step();
        rst_n = 1'b1;
        // single requester
        req = 4'b0100;
        step();
        chk("single_grant", grant, 4'b0100);
        chk("single_owner", owner, 2);
        chk("single_busy", busy, 1);
        done = 1'b1;
        step();
        chk("single_rel_grant", grant, 4'b0000);
        chk("single_rel_ptr", ptr, 4'b1000);
        done = 1'b0;
        step();
        chk("single_regrant", grant, 4'b0100);
        done = 1'b1;
        step();
        chk("single_rel2_ptr", ptr, 4'b1000);
        done = 1'b0; req = 4'b0011;
        // wrap and skip
        step();
        chk("wrap_grant", grant, 4'b0001);
        done = 1'b1;
        step();
        chk("wrap_ptr", ptr, 4'b0010);
        done = 1'b0;
        step();
        chk("skip_grant", grant, 4'b0010);
        done = 1'b1;
        step();
        chk("skip_ptr", ptr, 4'b0100);
        done = 1'b0; req = 4'b1111;
        // async reset mid-grant
        step();
        chk("pre_rst_grant", grant, 4'b0100);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_grant", grant, 4'b0000);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_ptr", ptr, 4'b0001);
        #3 rst_n = 1'b1;
        // rotation with all requesting
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rot_grant", grant, rot[i]);
            done = 1'b1;
            step();
            chk("rot_gap", grant, 4'b0000);
            done = 1'b0;
        end
        chk("rot_ptr", ptr, 4'b0010);
        // withdrawal
        step();
        chk("wd_grant", grant, 4'b0010);
        chk("wd_owner", owner, 1);
        req = 4'b0000;
        step();
        chk("wd_rel_grant", grant, 4'b0000);
        chk("wd_rel_ptr", ptr, 4'b0100);
        done = 1'b1;
        step();
        chk("idle_done_grant", grant, 4'b0000);
        chk("idle_done_ptr", ptr, 4'b0100);
        chk("idle_done_busy", busy, 0);
        done = 1'b0; req = 4'b0010;
        step();
        chk("hold_grant", grant, 4'b0010);
        bad = 0;
`ifdef RING_ARB_TIMEOUT_EN
        for (int i = 1; i < 15; i++) begin
            step();
            if (grant !== 4'b0010 || timeout !== 1'b0) bad++;
        end
        chk("to_hold_cycles", bad, 0);
        step();
        chk("to_grant", grant, 4'b0000);
        chk("to_pulse", timeout, 1);
        chk("to_ptr", ptr, 4'b0100);
        step();
        chk("to_regrant", grant, 4'b0010);
        chk("to_pulse_end", timeout, 0);
`else
        for (int i = 0; i < 100; i++) begin
            step();
            if (grant !== 4'b0010 || timeout !== 1'b0) bad++;
        end
        chk("hold_cycles", bad, 0);
        chk("hold_ptr", ptr, 4'b0100);
        chk("hold_timeout", timeout, 0);
`endif
        done = 1'b1;
        step();
        chk("final_rel", grant, 4'b0000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
